wallace_mul8_seq: RTL and testbench

Multi-cycle 8x8 unsigned multiplier controller. It time-shares one instance of the team's combinational 4x4 `wallace` multiplier (ports A[3:0], B[3:0], prod[7:0]) over four nibble partial products. It accumulates them into a 16-bit result and presents it through valid/ready handshakes on both sides. It sits between a requester that needs 8-bit products and the existing 4x4 Wallace datapath, and adds no second multiplier array.

---
 rtl/wallace_mul8_seq.sv | 148 ++++++++++++++
 tb/tb_wallace_mul8_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/wallace_mul8_seq.sv
// wallace_mul8_seq: 8x8 unsigned multiplier that time-shares a single
// combinational 4x4 Wallace multiplier over four nibble partial products.
// Operands are captured on the input handshake. The product is accumulated
// over P0..P3 and then held in DONE until the consumer takes it.

// 4x4 unsigned Wallace-tree multiplier. First layer reduces the bit heap
// with per-column full/half adders, a carry-save layer then folds three rows
// into two, and a final carry-propagate add produces the product.
module wallace (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] prod
);
  logic [3:0][3:0] pp;       // pp[i][j] = A[i] & B[j], weight i+j
  logic s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;
  logic [7:0] r0, r1, r2, csa_s, csa_c;

  // Partial-product bit matrix
  always_comb begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        pp[i][j] = A[i] & B[j];
  end

  // First reduction layer, one adder per column of height >= 2
  always_comb begin
    {c1, s1} = {1'b0, pp[0][1]} + {1'b0, pp[1][0]};
    {c2, s2} = {1'b0, pp[0][2]} + {1'b0, pp[1][1]} + {1'b0, pp[2][0]};
    {c3, s3} = {1'b0, pp[0][3]} + {1'b0, pp[1][2]} + {1'b0, pp[2][1]};
    {c4, s4} = {1'b0, pp[1][3]} + {1'b0, pp[2][2]} + {1'b0, pp[3][1]};
    {c5, s5} = {1'b0, pp[2][3]} + {1'b0, pp[3][2]};
  end

  // Remaining bits regrouped into three rows, then one carry-save layer
  always_comb begin
    r0    = {1'b0, pp[3][3], s5, s4, s3, s2, s1, pp[0][0]};
    r1    = {1'b0, c5, c4, c3, pp[3][0], c1, 2'b00};
    r2    = {4'b0000, c2, 3'b000};
    csa_s = r0 ^ r1 ^ r2;
    csa_c = {((r0[6:0] & r1[6:0]) | (r0[6:0] & r2[6:0]) | (r1[6:0] & r2[6:0])), 1'b0};
    prod  = csa_s + csa_c;
  end
endmodule

module wallace_mul8_seq #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         a,
  input  logic [7:0]         b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        prod,
  output logic               busy,
  output logic [COUNT_W-1:0] ops_done
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P0   = 3'd1;
  localparam logic [2:0] S_P1   = 3'd2;
  localparam logic [2:0] S_P2   = 3'd3;
  localparam logic [2:0] S_P3   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [7:0]         a_q, a_d, b_q, b_d;
  logic [15:0]        acc_q, acc_d;
  logic [COUNT_W-1:0] ops_q, ops_d;

  logic [3:0]  w_a, w_b;
  logic [7:0]  w_pp;
  logic [15:0] pp_sh;

  wallace u_wallace (
    .A    (w_a),
    .B    (w_b),
    .prod (w_pp)
  );

  // Nibble select and partial-product alignment for the current phase.
  // IDLE/DONE leave the multiplier on the low nibbles and add nothing.
  always_comb begin
    w_a   = a_q[3:0];
    w_b   = b_q[3:0];
    pp_sh = '0;
    case (state_q)
      S_P0: begin w_a = a_q[3:0]; w_b = b_q[3:0]; pp_sh = {8'h00, w_pp};        end
      S_P1: begin w_a = a_q[3:0]; w_b = b_q[7:4]; pp_sh = {4'h0, w_pp, 4'h0};   end
      S_P2: begin w_a = a_q[7:4]; w_b = b_q[3:0]; pp_sh = {4'h0, w_pp, 4'h0};   end
      S_P3: begin w_a = a_q[7:4]; w_b = b_q[7:4]; pp_sh = {w_pp, 8'h00};        end
      default: ;
    endcase
  end

  // Next-state, operand capture, accumulation and delivery counting
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    ops_d   = ops_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        acc_d   = '0;
        state_d = S_P0;
      end
      S_P0: begin acc_d = acc_q + pp_sh; state_d = S_P1;   end
      S_P1: begin acc_d = acc_q + pp_sh; state_d = S_P2;   end
      S_P2: begin acc_d = acc_q + pp_sh; state_d = S_P3;   end
      S_P3: begin acc_d = acc_q + pp_sh; state_d = S_DONE; end
      S_DONE: if (out_ready) begin
        ops_d   = ops_q + COUNT_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      ops_q   <= ops_d;
    end
  end

  // Outputs decode from state and registers only
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    prod      = acc_q;
    ops_done  = ops_q;
  end
endmodule

// File: tb/tb_wallace_mul8_seq.sv
// Directed bench for wallace_mul8_seq with a product scoreboard.
module tb_wallace_mul8_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] prod;
  logic [1:0]  ops_done;

  int n_pass = 0;
  int n_tot  = 0;
  int exp_ops = 0;
  logic [15:0] sb[$];

  wallace_mul8_seq #(.COUNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_ops = 0;
  endtask

  task automatic chk_idle(input string tag, input logic [1:0] exp_cnt);
    chk({tag, "_in_ready"},  in_ready,  1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_prod"},      prod,      0);
    chk({tag, "_ops_done"},  ops_done,  exp_cnt);
  endtask

  // One complete operation: accept, wait for result, optional stall, deliver
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        input int stall, input logic hold_ready);
    int t;
    logic [15:0] e, held;
    out_ready = hold_ready;
    t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    chk("in_ready_wait", in_ready, 1);
    a = ia; b = ib; in_valid = 1'b1;
    e = ia * ib;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
    chk("busy_after_accept", busy, 1);
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    chk("latency", t, 4);
    held = prod;
    for (int s = 0; s < stall; s++) begin
      in_valid = ~in_valid; a = 8'h55; b = 8'h55;
      @(negedge clk);
      chk("stall_prod", prod, held);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    e = sb.pop_front();
    chk("prod", prod, e);
    @(negedge clk);
    exp_ops = (exp_ops + 1) % 4;
    chk("ops_done", ops_done, exp_ops);
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
    out_ready = hold_ready;
  endtask

  initial begin
    logic [15:0] ps [4];
    logic [1:0]  prior;
    logic [7:0]  bl [8];
    ps = '{16'h0008, 16'h0068, 16'h00A8, 16'h03A8};
    bl = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h55, 8'hAA, 8'hF0, 8'hFF};

    // Reset state
    do_reset();
    chk_idle("reset", 2'd0);

    // Reset in P2 abandons the operation
    prior = ops_done;
    a = 8'hAB; b = 8'hCD; in_valid = 1'b1;
    @(negedge clk);              // P0
    in_valid = 1'b0;
    @(negedge clk);              // P1
    @(negedge clk);              // P2
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("midrst", prior);
    run_op(8'h03, 8'h05, 0, 1'b0);

    // Basic product with partial sums, out_ready held high
    do_reset();
    chk_idle("reset2", 2'd0);
    out_ready = 1'b1;
    a = 8'h12; b = 8'h34; in_valid = 1'b1;
    sb.push_back(16'h03A8);
    @(negedge clk);
    in_valid = 1'b0;
    chk("basic_acc_clear", prod, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("basic_psum", prod, ps[i]);
      chk("basic_out_valid", out_valid, (i == 3) ? 1 : 0);
    end
    chk("basic_prod", prod, sb.pop_front());
    @(negedge clk);
    exp_ops = 1;
    chk("basic_ops_done", ops_done, 1);
    chk("basic_in_ready", in_ready, 1);

    // Extremes back-to-back
    run_op(8'hFF, 8'hFF, 0, 1'b1);
    run_op(8'h00, 8'hA5, 0, 1'b1);
    run_op(8'h80, 8'h02, 0, 1'b1);

    // Backpressure with ignored requests during the stall
    run_op(8'h0F, 8'hF0, 10, 1'b0);

    // Counter wrap: 1,2,3,0,1
    do_reset();
    for (int i = 0; i < 5; i++) run_op(8'(i + 7), 8'(3 * i + 1), 0, 1'b0);

    // Sweep: every multiplicand against corner multipliers, random stalls
    for (int ia = 0; ia < 256; ia++)
      for (int j = 0; j < 8; j++)
        run_op(8'(ia), bl[j], int'($urandom_range(0, 2)), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
